// File: rtl/div_unit.sv
// Iterative 32-bit divider for the execute stage (DIV / DIVU).
// One restoring shift-subtract step per cycle on operand magnitudes. Signs are
// applied when the last step retires. The quotient appears on LOResultE and the
// remainder on HIResultE.
module div_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] SrcAE,
  input  logic [31:0] SrcBE,
  input  logic        DivStartE,
  input  logic        DivSignedE,
  input  logic        DivAnnulE,
  output logic        DivStallE,
  output logic        DivReadyE,
  output logic [31:0] HIResultE,
  output logic [31:0] LOResultE
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} divState_t;

  divState_t   state, stateNext;
  logic [5:0]  stepCnt;
  logic [31:0] rem, quo, divisor, dividendRaw;
  logic        negQuo, negRem;
  logic        accept, lastStep, stepGeq;
  logic [32:0] partial;
  logic [31:0] stepDiff, stepRem, stepQuo;
  logic [31:0] absA, absB, finQuo, finRem;

  assign accept   = (state == IDLE) && DivStartE && !DivAnnulE;
  assign lastStep = (state == BUSY) && (stepCnt == 6'd31);

  // Operand magnitudes; DIVU passes raw values through.
  always_comb begin
    absA = (DivSignedE && SrcAE[31]) ? (~SrcAE + 32'd1) : SrcAE;
    absB = (DivSignedE && SrcBE[31]) ? (~SrcBE + 32'd1) : SrcBE;
  end

  // One restoring step. When partial[32] is set, partial is above any 32-bit
  // divisor, and the true difference still fits in 32 bits.
  always_comb begin
    partial  = {rem, quo[31]};
    stepGeq  = partial[32] || (partial[31:0] >= divisor);
    stepDiff = partial[31:0] - divisor;
    stepRem  = stepGeq ? stepDiff : partial[31:0];
    stepQuo  = {quo[30:0], stepGeq};
  end

  // Sign correction of the final step. A zero divisor bypasses it and returns
  // all-ones / the raw dividend.
  always_comb begin
    if (divisor == 32'd0) begin
      finQuo = 32'hFFFF_FFFF;
      finRem = dividendRaw;
    end else begin
      finQuo = negQuo ? (~stepQuo + 32'd1) : stepQuo;
      finRem = negRem ? (~stepRem + 32'd1) : stepRem;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= stateNext;
  end

  // Next state and the handshake outputs; reset masks both outputs at once.
  always_comb begin
    stateNext = state;
    DivStallE = 1'b0;
    DivReadyE = 1'b0;
    case (state)
      IDLE: begin
        DivStallE = DivStartE && !DivAnnulE;
        if (accept) stateNext = BUSY;
      end
      BUSY: begin
        DivStallE = 1'b1;
        if (DivAnnulE)     stateNext = IDLE;
        else if (lastStep) stateNext = DONE;
      end
      DONE: begin
        DivReadyE = 1'b1;
        stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
    if (!rst) begin
      DivStallE = 1'b0;
      DivReadyE = 1'b0;
    end
  end

  // Datapath: latch operands on start, iterate in BUSY, retire on the last step.
  always_ff @(posedge clk) begin
    if (!rst) begin
      stepCnt     <= 6'd0;
      rem         <= 32'd0;
      quo         <= 32'd0;
      divisor     <= 32'd0;
      dividendRaw <= 32'd0;
      negQuo      <= 1'b0;
      negRem      <= 1'b0;
      HIResultE   <= 32'd0;
      LOResultE   <= 32'd0;
    end else if (accept) begin
      stepCnt     <= 6'd0;
      rem         <= 32'd0;
      quo         <= absA;
      divisor     <= absB;
      dividendRaw <= SrcAE;
      negQuo      <= DivSignedE && (SrcAE[31] ^ SrcBE[31]);
      negRem      <= DivSignedE && SrcAE[31];
    end else if (state == BUSY && !DivAnnulE) begin
      rem     <= stepRem;
      quo     <= stepQuo;
      stepCnt <= stepCnt + 6'd1;
      if (lastStep) begin
        HIResultE <= finRem;
        LOResultE <= finQuo;
      end
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Randomized and directed bench for div_unit against an arithmetic reference.
module tb_div_unit;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] SrcAE = '0, SrcBE = '0;
  logic        DivStartE = 1'b0, DivSignedE = 1'b0, DivAnnulE = 1'b0;
  logic        DivStallE, DivReadyE;
  logic [31:0] HIResultE, LOResultE;

  int nChecks = 0;
  int nErrors = 0;
  logic [31:0] expLo = '0, expHi = '0;

  div_unit dut (
    .clk(clk), .rst(rst), .SrcAE(SrcAE), .SrcBE(SrcBE),
    .DivStartE(DivStartE), .DivSignedE(DivSignedE), .DivAnnulE(DivAnnulE),
    .DivStallE(DivStallE), .DivReadyE(DivReadyE),
    .HIResultE(HIResultE), .LOResultE(LOResultE)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChecks++;
    if (obs !== exp) begin
      nErrors++;
      $display("FAIL %s got %h want %h", tag, obs, exp);
    end
  endtask

  // Reference model: {remainder, quotient} from plain integer arithmetic.
  function automatic logic [63:0] refDiv(input logic [31:0] a, input logic [31:0] b, input logic s);
    longint sa, sb, q, r;
    if (b == 32'd0) return {a, 32'hFFFF_FFFF};
    if (s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end else begin
      sa = longint'({32'd0, a});
      sb = longint'({32'd0, b});
    end
    q = sa / sb;
    r = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  // Full divide: start at cycle 0, hold start into BUSY, scramble operands
  // afterwards, and expect ready at cycle 33 with 33 stall cycles before it.
  task automatic runDiv(input logic [31:0] a, input logic [31:0] b, input logic s, input string tag);
    int cyc, stallCnt;
    logic gotReady;
    logic [63:0] r;
    r = refDiv(a, b, s);
    @(negedge clk);
    SrcAE = a; SrcBE = b; DivSignedE = s; DivStartE = 1'b1; DivAnnulE = 1'b0;
    #1;
    stallCnt = DivStallE ? 1 : 0;
    cyc = 0;
    gotReady = 1'b0;
    while (!gotReady && cyc < 40) begin
      @(negedge clk);
      cyc++;
      DivStartE = (cyc < 20);
      SrcAE = $urandom; SrcBE = $urandom; DivSignedE = 1'($urandom_range(0, 1));
      #1;
      if (DivReadyE) gotReady = 1'b1;
      else if (DivStallE) stallCnt++;
    end
    chk({tag, ".readyCycle"}, cyc, 33);
    chk({tag, ".stallCycles"}, stallCnt, 33);
    chk({tag, ".lo"}, LOResultE, r[31:0]);
    chk({tag, ".hi"}, HIResultE, r[63:32]);
    expLo = r[31:0];
    expHi = r[63:32];
    DivStartE = 1'b0;
    @(negedge clk); #1;
    chk({tag, ".readyDrop"}, 32'(DivReadyE), 0);
    chk({tag, ".loHeld"}, LOResultE, expLo);
  endtask

  initial begin
    int cyc, rdyCnt, rdyCyc0, rdyCyc1;
    logic [31:0] a, b;
    int sel;

    // Reset with start asserted: nothing may start, everything is zero.
    DivStartE = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk("rst.stall", 32'(DivStallE), 0);
    chk("rst.ready", 32'(DivReadyE), 0);
    chk("rst.hi", HIResultE, 0);
    chk("rst.lo", LOResultE, 0);
    @(negedge clk);
    rst = 1'b1; DivStartE = 1'b0;

    // Directed cases.
    runDiv(32'd100, 32'd7, 1'b0, "divu100_7");
    chk("divu100_7.lo14", expLo, 32'd14);
    runDiv(32'hFFFF_FFF9, 32'd2, 1'b1, "divNeg7_2");
    runDiv(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, "divOvf");
    runDiv(32'd5, 32'd0, 1'b0, "divuBy0");
    runDiv(32'hFFFF_FFFB, 32'd0, 1'b1, "divBy0");

    // Annul mid-divide at cycle 10.
    @(negedge clk);
    SrcAE = 32'd100; SrcBE = 32'd7; DivSignedE = 1'b0; DivStartE = 1'b1;
    rdyCnt = 0;
    for (cyc = 1; cyc <= 45; cyc++) begin
      @(negedge clk);
      DivStartE = 1'b0;
      DivAnnulE = (cyc == 10);
      #1;
      if (cyc == 10) chk("annul.stallAt10", 32'(DivStallE), 1);
      if (cyc == 11) chk("annul.stallAt11", 32'(DivStallE), 0);
      if (DivReadyE) rdyCnt++;
    end
    DivAnnulE = 1'b0;
    chk("annul.noReady", rdyCnt, 0);
    chk("annul.loKept", LOResultE, expLo);
    chk("annul.hiKept", HIResultE, expHi);

    // Annul beats start while idle.
    @(negedge clk);
    DivStartE = 1'b1; DivAnnulE = 1'b1;
    #1;
    chk("idleAnnul.stall", 32'(DivStallE), 0);
    rdyCnt = 0;
    repeat (36) begin
      @(negedge clk);
      DivStartE = 1'b0; DivAnnulE = 1'b0;
      #1;
      if (DivReadyE || DivStallE) rdyCnt++;
    end
    chk("idleAnnul.quiet", rdyCnt, 0);

    // Reset at cycle 15 of a divide.
    @(negedge clk);
    SrcAE = 32'd200; SrcBE = 32'd9; DivStartE = 1'b1;
    for (cyc = 1; cyc <= 15; cyc++) begin
      @(negedge clk);
      DivStartE = 1'b0;
    end
    rst = 1'b0; DivStartE = 1'b1;
    @(negedge clk);
    rst = 1'b1; DivStartE = 1'b0;
    #1;
    chk("midRst.stall", 32'(DivStallE), 0);
    chk("midRst.ready", 32'(DivReadyE), 0);
    chk("midRst.hi", HIResultE, 0);
    chk("midRst.lo", LOResultE, 0);
    runDiv(32'd9, 32'd3, 1'b0, "afterRst");

    // Back-to-back with start held through DONE.
    @(negedge clk);
    SrcAE = 32'd20; SrcBE = 32'd3; DivSignedE = 1'b0; DivStartE = 1'b1;
    rdyCnt = 0; rdyCyc0 = -1; rdyCyc1 = -1;
    for (cyc = 1; cyc <= 75; cyc++) begin
      @(negedge clk);
      if (cyc == 1) begin SrcAE = 32'd50; SrcBE = 32'd8; end
      if (rdyCnt >= 2) DivStartE = 1'b0;
      #1;
      if (DivReadyE) begin
        if (rdyCnt == 0) rdyCyc0 = cyc; else rdyCyc1 = cyc;
        rdyCnt++;
        chk("b2b.lo", LOResultE, 32'd6);
        chk("b2b.hi", HIResultE, 32'd2);
      end
    end
    DivStartE = 1'b0;
    chk("b2b.pulses", rdyCnt, 2);
    chk("b2b.cycle1", rdyCyc0, 33);
    chk("b2b.cycle2", rdyCyc1, 67);

    // Randomized operands, biased toward the awkward divisors.
    for (int i = 0; i < 24; i++) begin
      sel = $urandom_range(0, 7);
      a = (sel == 7) ? 32'h8000_0000 : $urandom;
      case (sel)
        0:       b = 32'd0;
        1:       b = 32'($urandom_range(1, 15));
        2, 7:    b = 32'hFFFF_FFFF;
        3:       b = a;
        default: b = $urandom;
      endcase
      runDiv(a, b, 1'($urandom_range(0, 1)), $sformatf("rand%0d", i));
    end

    $display("CHECKS %0d ERRORS %0d", nChecks, nErrors);
    $finish;
  end
endmodule

// File: doc/div_unit.md
DIV_UNIT -- requirements
Module: div_unit

Interface
REQ-001 SHALL have one clock; reset is synchronous and active-low.
REQ-002 clk  input  1  rising-edge clock, sole clock domain.
REQ-003 rst  input  1  synchronous active-low reset, sampled on rising clk.
REQ-004 SrcAE  input  32  dividend, execute-stage operand after forwarding mux.
REQ-005 SrcBE  input  32  divisor, execute-stage operand after forwarding mux.
REQ-006 DivStartE  input  1  a DIV/DIVU instruction occupies execute.
REQ-007 DivSignedE  input  1  1 = DIV (two's complement), 0 = DIVU.
REQ-008 DivAnnulE  input  1  execute-stage instruction is being cancelled (exception/flush).
REQ-009 DivStallE  output  1  hold fetch/decode/execute; the hazard unit ORs it into StallF/StallD and holds E.
REQ-010 DivReadyE  output  1  one-cycle pulse: HIResultE/LOResultE valid for the HIWrite/LOWrite path into memory stage.
REQ-011 HIResultE  output  32  remainder.
REQ-012 LOResultE  output  32  quotient.

Function
REQ-013 States SHALL be IDLE, BUSY, DONE; a 6-bit counter SHALL track BUSY iterations.
REQ-014 IDLE: DivStartE=1 and DivAnnulE=0 SHALL latch |SrcAE|, |SrcBE| (raw values if DivSignedE=0), sign of quotient (signA^signB) and sign of remainder (signA), clear counter, go BUSY.
REQ-015 BUSY: SHALL perform one restoring shift-subtract step per cycle; after the 32nd step go DONE.
REQ-016 DONE: SHALL assert DivReadyE for exactly one cycle, ignore DivStartE, go IDLE next cycle unconditionally.
REQ-017 Latency: start sampled at cycle 0, steps in cycles 1..32, DivReadyE=1 in cycle 33; back-to-back divides SHALL be accepted in the first IDLE cycle after DONE.
REQ-018 DivStallE SHALL be combinational: (IDLE & DivStartE & !DivAnnulE) | BUSY; 0 in DONE so the pipeline advances that cycle.
REQ-019 Signed results: quotient negated if quotient sign set; remainder negated if dividend negative; magnitudes mod 2^32.
REQ-020 Overflow 0x80000000 / 0xFFFFFFFF signed SHALL yield LO=0x80000000, HI=0x00000000.
REQ-021 Divide by zero (either mode) SHALL still take 32 steps and yield LO=0xFFFFFFFF, HI=SrcAE as latched, no sign correction.
REQ-022 DivAnnulE=1 in BUSY SHALL return to IDLE next cycle, DivStallE=0 from that cycle, no DivReadyE pulse, outputs unchanged.
REQ-023 DivAnnulE=1 in IDLE with DivStartE=1: annul wins, no start, DivStallE=0.
REQ-024 DivStartE in BUSY SHALL be ignored (operands not re-latched).
REQ-025 HIResultE/LOResultE SHALL update only on BUSY->DONE and hold until the next completed divide.

Reset
REQ-026 rst=0 SHALL force IDLE, counter=0, DivStallE=0, DivReadyE=0, HIResultE=0, LOResultE=0, from any state, including mid-BUSY; in-flight divide discarded.
REQ-027 rst=0 SHALL override DivStartE and DivAnnulE in the same cycle.

Verification
REQ-028 DIVU 100/7, start cycle 0 -> DivStallE=1 cycles 0..32, DivReadyE=1 cycle 33, LO=14, HI=2.
REQ-029 DIV 0xFFFFFFF9/2 (-7/2) -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIV 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0.
REQ-030 DIVU 5/0 and DIV 0xFFFFFFFB/0 -> LO=0xFFFFFFFF, HI=SrcAE, ready still at cycle 33.
REQ-031 DIVU 100/7, DivAnnulE=1 at cycle 10 -> DivStallE=0 from cycle 11, no DivReadyE, LO/HI keep prior values.
REQ-032 rst=0 at cycle 15 of a divide -> all outputs 0 next cycle; new DIVU 9/3 afterwards -> LO=3, HI=0 after 33 cycles.
REQ-033 Two back-to-back DIVU (20/3 then 50/8), DivStartE held high through DONE -> exactly two ready pulses, cycles 33 and 67, results (6,2) then (6,2).
